vending_machine_param: RTL and testbench

Parametrised successor to the single-product 15-rs vending FSM. Supports NUM_ITEMS products with per-item prices and stock, and three coin denominations. Adds selection, cancel/refund, and coin-by-coin change return. Sits between the coin acceptor/keypad front end and the dispenser/coin-hopper drivers.

---
 rtl/vending_machine_param.sv | 200 ++++++++++++++++++++
 tb/tb_vending_machine_param.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_param.sv
// Parametrised multi-item vending controller: coin credit, selection, cancel/refund and coin-by-coin change.
// Define VENDING_AUDIT_EN to build the saturating sales_total accumulator; otherwise sales_total is tied to 0.
module vending_machine_param #(
  parameter int NUM_ITEMS = 4,
  parameter int CREDIT_W = 8,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_LIST = 32'h19140F0A,
  parameter int COIN1 = 5,
  parameter int COIN2 = 10,
  parameter int COIN3 = 20,
  parameter int MAX_CREDIT = 100,
  parameter int STOCK_W = 4,
  parameter int STOCK_INIT = 8,
  localparam int ITEM_W = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           in,
  input  logic                 sel_valid,
  input  logic [ITEM_W-1:0]    sel,
  input  logic                 cancel,
  input  logic                 restock,
  output logic                 out,
  output logic [ITEM_W-1:0]    out_item,
  output logic [1:0]           change,
  output logic [CREDIT_W-1:0]  credit,
  output logic                 busy,
  output logic                 sel_reject,
  output logic                 coin_reject,
  output logic [NUM_ITEMS-1:0] sold_out,
  output logic [15:0]          sales_total
);

  localparam logic [CREDIT_W-1:0] C1 = COIN1[CREDIT_W-1:0];
  localparam logic [CREDIT_W-1:0] C2 = COIN2[CREDIT_W-1:0];
  localparam logic [CREDIT_W-1:0] C3 = COIN3[CREDIT_W-1:0];
  localparam logic [CREDIT_W:0]   MAX_C = MAX_CREDIT[CREDIT_W:0];
  localparam logic [ITEM_W:0]     NUM_ITEMS_L = NUM_ITEMS[ITEM_W:0];
  localparam logic [STOCK_W-1:0]  STOCK_INIT_L = STOCK_INIT[STOCK_W-1:0];

  typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

  state_t               state_reg, state_next;
  logic [CREDIT_W-1:0]  credit_reg, credit_next;
  logic                 out_reg, out_next;
  logic [ITEM_W-1:0]    out_item_reg, out_item_next;
  logic [1:0]           change_reg, change_next;
  logic                 sel_reject_reg, sel_reject_next;
  logic                 coin_reject_reg, coin_reject_next;
  logic [STOCK_W-1:0]   stock_reg [NUM_ITEMS];
  logic [STOCK_W-1:0]   stock_next [NUM_ITEMS];
  logic [CREDIT_W-1:0]  price [NUM_ITEMS];

  logic [CREDIT_W:0]    coin_val;
  logic [CREDIT_W:0]    credit_sum;
  logic [ITEM_W-1:0]    sel_idx;
  logic                 sel_ok;
  logic [1:0]           pay_code;
  logic [CREDIT_W-1:0]  pay_val;

  generate
    for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_item
      assign price[gi]    = PRICE_LIST[gi*CREDIT_W +: CREDIT_W];
      assign sold_out[gi] = (stock_reg[gi] == '0);
    end
  endgenerate

  always_comb begin
    coin_val = '0;
    case (in)
      2'b01:   coin_val = {1'b0, C1};
      2'b10:   coin_val = {1'b0, C2};
      2'b11:   coin_val = {1'b0, C3};
      default: coin_val = '0;
    endcase
  end

  assign credit_sum = {1'b0, credit_reg} + coin_val;
  assign sel_idx    = ({1'b0, sel} < NUM_ITEMS_L) ? sel : '0;
  assign sel_ok     = ({1'b0, sel} < NUM_ITEMS_L) && (credit_reg >= price[sel_idx])
                      && (stock_reg[sel_idx] != '0);

  // Largest coin that fits; a sub-COIN1 remainder is paid as "nothing" and simply cleared.
  always_comb begin
    pay_code = 2'b00;
    pay_val  = credit_reg;
    if (credit_reg >= C3) begin
      pay_code = 2'b11;
      pay_val  = C3;
    end else if (credit_reg >= C2) begin
      pay_code = 2'b10;
      pay_val  = C2;
    end else if (credit_reg >= C1) begin
      pay_code = 2'b01;
      pay_val  = C1;
    end
  end

  always_comb begin
    state_next       = state_reg;
    credit_next      = credit_reg;
    out_next         = 1'b0;
    out_item_next    = '0;
    change_next      = 2'b00;
    sel_reject_next  = 1'b0;
    coin_reject_next = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) stock_next[i] = stock_reg[i];

    case (state_reg)
      IDLE, CREDIT: begin
        if (cancel) begin
          coin_reject_next = |in;
          if (state_reg == CREDIT) begin
            change_next = pay_code;
            credit_next = credit_reg - pay_val;
            state_next  = (pay_code != 2'b00) ? CHANGE : IDLE;
          end
        end else if (sel_valid) begin
          coin_reject_next = |in;
          if (sel_ok) begin
            out_next            = 1'b1;
            out_item_next       = sel_idx;
            credit_next         = credit_reg - price[sel_idx];
            stock_next[sel_idx] = stock_reg[sel_idx] - STOCK_W'(1);
            state_next          = VEND;
          end else begin
            sel_reject_next = 1'b1;
          end
        end else if (in != 2'b00) begin
          if (credit_sum > MAX_C) begin
            coin_reject_next = 1'b1;
          end else begin
            credit_next = credit_sum[CREDIT_W-1:0];
            state_next  = CREDIT;
          end
        end
        if (restock && state_reg == IDLE) begin
          for (int i = 0; i < NUM_ITEMS; i++) stock_next[i] = STOCK_INIT_L;
        end
      end
      VEND, CHANGE: begin
        // Paying out with zero credit left drives no coin and ends the sequence.
        coin_reject_next = |in;
        change_next      = pay_code;
        credit_next      = credit_reg - pay_val;
        state_next       = (pay_code != 2'b00) ? CHANGE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      credit_reg      <= '0;
      out_reg         <= 1'b0;
      out_item_reg    <= '0;
      change_reg      <= 2'b00;
      sel_reject_reg  <= 1'b0;
      coin_reject_reg <= 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++) stock_reg[i] <= STOCK_INIT_L;
    end else begin
      state_reg       <= state_next;
      credit_reg      <= credit_next;
      out_reg         <= out_next;
      out_item_reg    <= out_item_next;
      change_reg      <= change_next;
      sel_reject_reg  <= sel_reject_next;
      coin_reject_reg <= coin_reject_next;
      for (int i = 0; i < NUM_ITEMS; i++) stock_reg[i] <= stock_next[i];
    end
  end

  assign out         = out_reg;
  assign out_item    = out_item_reg;
  assign change      = change_reg;
  assign credit      = credit_reg;
  assign sel_reject  = sel_reject_reg;
  assign coin_reject = coin_reject_reg;
  assign busy        = (state_reg == VEND) || (state_reg == CHANGE);

`ifdef VENDING_AUDIT_EN
  logic [15:0] sales_reg;
  logic [16:0] sales_sum;

  assign sales_sum = {1'b0, sales_reg} + {{(17-CREDIT_W){1'b0}}, price[out_item_reg]};

  always_ff @(posedge clk) begin
    if (rst) begin
      sales_reg <= '0;
    end else if (out_reg) begin
      sales_reg <= sales_sum[16] ? 16'hFFFF : sales_sum[15:0];
    end
  end

  assign sales_total = sales_reg;
`else
  assign sales_total = '0;
`endif

endmodule

// File: tb/tb_vending_machine_param.sv
// Randomised + directed bench for vending_machine_param: a behavioural model queues expected outputs,
// a monitor pops and compares one snapshot per cycle.
module tb_vending_machine_param;
  localparam int N  = 4;
  localparam int SI = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   in = 2'b00;
  logic         sel_valid = 1'b0;
  logic [1:0]   sel = 2'b00;
  logic         cancel = 1'b0;
  logic         restock = 1'b0;
  logic         out;
  logic [1:0]   out_item;
  logic [1:0]   change;
  logic [7:0]   credit;
  logic         busy;
  logic         sel_reject;
  logic         coin_reject;
  logic [N-1:0] sold_out;
  logic [15:0]  sales_total;

  always #5 clk = ~clk;

  vending_machine_param #(.STOCK_INIT(SI)) dut (
    .clk(clk), .rst(rst), .in(in), .sel_valid(sel_valid), .sel(sel), .cancel(cancel),
    .restock(restock), .out(out), .out_item(out_item), .change(change), .credit(credit),
    .busy(busy), .sel_reject(sel_reject), .coin_reject(coin_reject), .sold_out(sold_out),
    .sales_total(sales_total)
  );

  typedef struct {
    int out; int item; int change; int credit; int busy;
    int sel_rej; int coin_rej; int sold; int total;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  // Reference model: credit as an integer, refunds as a precomputed list of coins to hand back.
  int price_tab[N] = '{10, 15, 20, 25};
  int coin_tab[4]  = '{0, 5, 10, 20};
  int m_credit;
  int m_stock[N];
  int m_phase;      // 0 taking coins, 1 dispensing, 2 refunding
  int m_item;
  int m_total;
  int m_pay[$];

  function automatic void start_refund(ref exp_t e);
    int amt;
    int code;
    amt = m_credit;
    m_pay.delete();
    while (amt >= 5) begin
      code = (amt >= 20) ? 3 : (amt >= 10) ? 2 : 1;
      m_pay.push_back(code);
      amt -= coin_tab[code];
    end
    if (m_pay.size() == 0) begin
      m_credit = 0;
      m_phase  = 0;
    end else begin
      code     = m_pay.pop_front();
      e.change = code;
      m_credit -= coin_tab[code];
      m_phase  = 2;
    end
  endfunction

  function automatic exp_t model_step(input bit r, input int i, input bit sv, input int s,
                                      input bit c, input bit rs);
    exp_t e;
    bit idle;
    e = '{default: 0};
    if (r) begin
      m_credit = 0; m_phase = 0; m_total = 0; m_pay.delete();
      for (int k = 0; k < N; k++) m_stock[k] = SI;
    end else begin
      case (m_phase)
        0: begin
          idle = (m_credit == 0);
          if (c) begin
            e.coin_rej = (i != 0);
            if (m_credit > 0) start_refund(e);
          end else if (sv) begin
            e.coin_rej = (i != 0);
            if (m_credit >= price_tab[s] && m_stock[s] > 0) begin
              m_stock[s]--; m_credit -= price_tab[s];
              e.out = 1; e.item = s; m_item = s; m_phase = 1;
            end else begin
              e.sel_rej = 1;
            end
          end else if (i != 0) begin
            if (m_credit + coin_tab[i] > 100) e.coin_rej = 1;
            else m_credit += coin_tab[i];
          end
          if (rs && idle) for (int k = 0; k < N; k++) m_stock[k] = SI;
        end
        1: begin
          e.coin_rej = (i != 0);
          m_total += price_tab[m_item];
          if (m_total > 65535) m_total = 65535;
          m_phase = 0;
          if (m_credit > 0) start_refund(e);
        end
        default: begin
          e.coin_rej = (i != 0);
          if (m_pay.size() > 0) begin
            e.change = m_pay.pop_front();
            m_credit -= coin_tab[e.change];
          end else begin
            m_phase = 0;
          end
        end
      endcase
    end
    e.credit = m_credit;
    e.busy   = (m_phase != 0);
    for (int k = 0; k < N; k++) if (m_stock[k] == 0) e.sold |= (1 << k);
`ifdef VENDING_AUDIT_EN
    e.total = m_total;
`else
    e.total = 0;
`endif
    return e;
  endfunction

  task automatic cyc(input bit r, input int i, input bit sv, input int s, input bit c, input bit rs);
    @(negedge clk);
    rst = r; in = 2'(i); sel_valid = sv; sel = 2'(s); cancel = c; restock = rs;
    sb.push_back(model_step(r, i, sv, s, c, rs));
  endtask

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  function automatic void chk(input string name, input int act, input int exp, input int cyc_no);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc_no, act, exp);
    end
  endfunction

  // Monitor: one expected snapshot per clock, compared just after the edge.
  int ncyc = 0;
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        ncyc++;
        chk("out",         int'(out),         e.out,      ncyc);
        chk("out_item",    int'(out_item),    e.item,     ncyc);
        chk("change",      int'(change),      e.change,   ncyc);
        chk("credit",      int'(credit),      e.credit,   ncyc);
        chk("busy",        int'(busy),        e.busy,     ncyc);
        chk("sel_reject",  int'(sel_reject),  e.sel_rej,  ncyc);
        chk("coin_reject", int'(coin_reject), e.coin_rej, ncyc);
        chk("sold_out",    int'(sold_out),    e.sold,     ncyc);
        chk("sales_total", int'(sales_total), e.total,    ncyc);
        $display("[TB] cyc %0d out=%0d item=%0d change=%0d credit=%0d busy=%0d srej=%0d crej=%0d sold=%0h total=%0d",
                 ncyc, out, out_item, change, credit, busy, sel_reject, coin_reject, sold_out, sales_total);
      end
    end
  end

  initial begin
    bit r, sv, c, rs;
    int i, s;
    // 1: 3 x COIN1 then item 1
    cyc(1, 0, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0); idle_n(2);
    // 2: COIN3, item 0, one COIN2 back
    cyc(0, 3, 0, 0, 0, 0); cyc(0, 0, 1, 0, 0, 0); idle_n(3);
    // 3: too little credit for item 3, then cancel
    cyc(0, 2, 0, 0, 0, 0); cyc(0, 0, 1, 3, 0, 0); idle_n(1); cyc(0, 0, 0, 0, 1, 0); idle_n(2);
    // 4: credit ceiling, then five COIN3 refunds
    for (int k = 0; k < 6; k++) cyc(0, 3, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0); idle_n(7);
    // 5: exhaust item 0, reject, restock
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin cyc(0, 2, 0, 0, 0, 0); cyc(0, 0, 1, 0, 0, 0); idle_n(2); end
    cyc(0, 2, 0, 0, 0, 0); cyc(0, 0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 1, 0); idle_n(2);
    cyc(0, 0, 0, 0, 0, 1); idle_n(1);
    // 6: reset during a refund, plus coins during busy and coin with sel/cancel
    cyc(0, 3, 0, 0, 0, 0); cyc(0, 3, 0, 0, 0, 0); cyc(0, 1, 0, 0, 1, 0); cyc(0, 2, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0); idle_n(2);
    cyc(0, 3, 0, 0, 0, 0); cyc(0, 1, 1, 0, 0, 0); idle_n(3);
    // Random traffic
    for (int k = 0; k < 3000; k++) begin
      r  = ($urandom_range(0, 199) == 0);
      i  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
      sv = ($urandom_range(0, 5) == 0);
      s  = int'($urandom_range(0, N - 1));
      c  = ($urandom_range(0, 19) == 0);
      rs = ($urandom_range(0, 29) == 0);
      cyc(r, i, sv, s, c, rs);
    end
    idle_n(2);
    repeat (4) @(posedge clk);
    #2;
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
